// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational EX reads, WB write commit, interrupt entry/mret and optional counters.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters and their user aliases.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
    parameter logic [31:0] MEPC_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] EX_CSR_raddr,
    output logic [31:0] EX_CSR_rdata,
    input  logic        WB_CSRWrite,
    input  logic [11:0] WB_CSR_waddr,
    input  logic [31:0] WB_CSR_wdata,
    input  logic        WB_retire,
    input  logic        WB_mret,
    input  logic        ext_irq,
    input  logic        tmr_irq,
    output logic        irq_req,
    input  logic        irq_ack,
    input  logic [31:0] irq_pc,
    output logic [31:0] trap_pc,
    output logic [31:0] mret_pc
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [31:0] CAUSE_EXT = {1'b1, 31'd11};
    localparam logic [31:0] CAUSE_TMR = {1'b1, 31'd7};

    logic        mie_bit_q,  mie_bit_d;
    logic        mpie_bit_q, mpie_bit_d;
    logic        meie_q,     meie_d;
    logic        mtie_q,     mtie_d;
    logic        meip_q,     mtip_q;
    logic [31:2] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:2] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    logic        ext_pend;
    logic        tmr_pend;
    logic        take_irq;
    logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;

    assign ext_pend = meip_q & meie_q;
    assign tmr_pend = mtip_q & mtie_q;
    assign irq_req  = mie_bit_q & (ext_pend | tmr_pend);
    assign take_irq = irq_ack & irq_req;

    assign trap_pc = {mtvec_q, 2'b00};
    assign mret_pc = {mepc_q, 2'b00};

    assign wr_mstatus  = WB_CSRWrite && (WB_CSR_waddr == ADDR_MSTATUS);
    assign wr_mie      = WB_CSRWrite && (WB_CSR_waddr == ADDR_MIE);
    assign wr_mtvec    = WB_CSRWrite && (WB_CSR_waddr == ADDR_MTVEC);
    assign wr_mscratch = WB_CSRWrite && (WB_CSR_waddr == ADDR_MSCRATCH);
    assign wr_mepc     = WB_CSRWrite && (WB_CSR_waddr == ADDR_MEPC);
    assign wr_mcause   = WB_CSRWrite && (WB_CSR_waddr == ADDR_MCAUSE);

    // Priority on mstatus/mepc/mcause: trap entry, then mret, then CSR write.
    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_bit_d = mpie_bit_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (take_irq) begin
            mpie_bit_d = mie_bit_q;
            mie_bit_d  = 1'b0;
            mepc_d     = irq_pc[31:2];
            mcause_d   = ext_pend ? CAUSE_EXT : CAUSE_TMR;
        end else begin
            if (WB_mret) begin
                mie_bit_d  = mpie_bit_q;
                mpie_bit_d = 1'b1;
            end else if (wr_mstatus) begin
                mie_bit_d  = WB_CSR_wdata[3];
                mpie_bit_d = WB_CSR_wdata[7];
            end
            if (wr_mepc) begin
                mepc_d = WB_CSR_wdata[31:2];
            end
            if (wr_mcause) begin
                mcause_d = WB_CSR_wdata;
            end
        end
    end

    always_comb begin
        meie_d     = meie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        if (wr_mie) begin
            meie_d = WB_CSR_wdata[11];
            mtie_d = WB_CSR_wdata[7];
        end
        if (wr_mtvec) begin
            mtvec_d = WB_CSR_wdata[31:2];
        end
        if (wr_mscratch) begin
            mscratch_d = WB_CSR_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_bit_q  <= 1'b0;
            mpie_bit_q <= 1'b0;
            meie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            meip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET[31:2];
            mscratch_q <= 32'h0;
            mepc_q     <= MEPC_RESET[31:2];
            mcause_q   <= 32'h0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_bit_q <= mpie_bit_d;
            meie_q     <= meie_d;
            mtie_q     <= mtie_d;
            meip_q     <= ext_irq;
            mtip_q     <= tmr_irq;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;

    assign wr_mcycle_lo   = WB_CSRWrite && (WB_CSR_waddr == ADDR_MCYCLE);
    assign wr_mcycle_hi   = WB_CSRWrite && (WB_CSR_waddr == ADDR_MCYCLEH);
    assign wr_minstret_lo = WB_CSRWrite && (WB_CSR_waddr == ADDR_MINSTRET);
    assign wr_minstret_hi = WB_CSRWrite && (WB_CSR_waddr == ADDR_MINSTRETH);

    // A write to either half replaces that half and skips this cycle's increment.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_mcycle_lo) begin
            mcycle_d = {mcycle_q[63:32], WB_CSR_wdata};
        end else if (wr_mcycle_hi) begin
            mcycle_d = {WB_CSR_wdata, mcycle_q[31:0]};
        end
    end

    always_comb begin
        minstret_d = minstret_q;
        if (wr_minstret_lo) begin
            minstret_d = {minstret_q[63:32], WB_CSR_wdata};
        end else if (wr_minstret_hi) begin
            minstret_d = {WB_CSR_wdata, minstret_q[31:0]};
        end else if (WB_retire) begin
            minstret_d = minstret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = WB_retire;
`endif

    logic unused_low_bits;
    assign unused_low_bits = ^{irq_pc[1:0]};

    always_comb begin
        EX_CSR_rdata = 32'h0;
        case (EX_CSR_raddr)
            ADDR_MSTATUS:   EX_CSR_rdata = {19'h0, 2'b11, 3'b000, mpie_bit_q, 3'b000, mie_bit_q, 3'b000};
            ADDR_MIE:       EX_CSR_rdata = {20'h0, meie_q, 3'b000, mtie_q, 7'h0};
            ADDR_MIP:       EX_CSR_rdata = {20'h0, meip_q, 3'b000, mtip_q, 7'h0};
            ADDR_MTVEC:     EX_CSR_rdata = {mtvec_q, 2'b00};
            ADDR_MSCRATCH:  EX_CSR_rdata = mscratch_q;
            ADDR_MEPC:      EX_CSR_rdata = {mepc_q, 2'b00};
            ADDR_MCAUSE:    EX_CSR_rdata = mcause_q;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,
            ADDR_CYCLE:     EX_CSR_rdata = mcycle_q[31:0];
            ADDR_MCYCLEH,
            ADDR_CYCLEH:    EX_CSR_rdata = mcycle_q[63:32];
            ADDR_MINSTRET,
            ADDR_INSTRET:   EX_CSR_rdata = minstret_q[31:0];
            ADDR_MINSTRETH,
            ADDR_INSTRETH:  EX_CSR_rdata = minstret_q[63:32];
`endif
            default:        EX_CSR_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset values, read timing, interrupt entry/mret priority, async reset, counters.
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic [11:0] EX_CSR_raddr;
    logic [31:0] EX_CSR_rdata;
    logic        WB_CSRWrite;
    logic [11:0] WB_CSR_waddr;
    logic [31:0] WB_CSR_wdata;
    logic        WB_retire;
    logic        WB_mret;
    logic        ext_irq;
    logic        tmr_irq;
    logic        irq_req;
    logic        irq_ack;
    logic [31:0] irq_pc;
    logic [31:0] trap_pc;
    logic [31:0] mret_pc;

    int n_cmp;
    int n_bad;

    csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .EX_CSR_raddr (EX_CSR_raddr),
        .EX_CSR_rdata (EX_CSR_rdata),
        .WB_CSRWrite  (WB_CSRWrite),
        .WB_CSR_waddr (WB_CSR_waddr),
        .WB_CSR_wdata (WB_CSR_wdata),
        .WB_retire    (WB_retire),
        .WB_mret      (WB_mret),
        .ext_irq      (ext_irq),
        .tmr_irq      (tmr_irq),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .irq_pc       (irq_pc),
        .trap_pc      (trap_pc),
        .mret_pc      (mret_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
        EX_CSR_raddr = addr;
        #1;
        check_val(tag, EX_CSR_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        WB_CSRWrite  = 1'b1;
        WB_CSR_waddr = addr;
        WB_CSR_wdata = data;
        tick();
        WB_CSRWrite  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        EX_CSR_raddr = 12'h0;
        WB_CSRWrite = 1'b0;
        WB_CSR_waddr = 12'h0;
        WB_CSR_wdata = 32'h0;
        WB_retire = 1'b0;
        WB_mret = 1'b0;
        ext_irq = 1'b0;
        tmr_irq = 1'b0;
        irq_ack = 1'b0;
        irq_pc = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        rd(12'h305, "rst_mtvec", 32'h0001_0000);
        rd(12'h300, "rst_mstatus", 32'h0000_1800);
        rd(12'h7C0, "rst_unmapped", 32'h0);
        rd(12'h341, "rst_mepc", 32'h0);
        rd(12'h344, "rst_mip", 32'h0);
        check_val("rst_irq_req", {31'h0, irq_req}, 32'h0);
        check_val("rst_trap_pc", trap_pc, 32'h0001_0000);
        check_val("rst_mret_pc", mret_pc, 32'h0);

        // Write is not visible until the following cycle
        EX_CSR_raddr = 12'h340;
        WB_CSRWrite  = 1'b1;
        WB_CSR_waddr = 12'h340;
        WB_CSR_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("mscratch_same_cycle", EX_CSR_rdata, 32'h0);
        tick();
        WB_CSRWrite = 1'b0;
        rd(12'h340, "mscratch_next", 32'hDEAD_BEEF);

        // Field masking and dropped writes
        wr(12'h305, 32'h0002_0007);
        rd(12'h305, "mtvec_mask", 32'h0002_0004);
        check_val("trap_pc_mask", trap_pc, 32'h0002_0004);
        wr(12'h341, 32'h0000_0403);
        rd(12'h341, "mepc_mask", 32'h0000_0400);
        wr(12'h344, 32'hFFFF_FFFF);
        rd(12'h344, "mip_ro", 32'h0);
        wr(12'h7C0, 32'h1234_5678);
        rd(12'h7C0, "unmapped_wr", 32'h0);
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, "mstatus_mask", 32'h0000_1888);

        // Interrupt entry with both sources pending
        wr(12'h304, 32'h0000_0880);
        wr(12'h300, 32'h0000_0008);
        rd(12'h304, "mie_rd", 32'h0000_0880);
        ext_irq = 1'b1;
        tmr_irq = 1'b1;
        #1;
        check_val("irq_req_before_mip", {31'h0, irq_req}, 32'h0);
        tick();
        tick();
        check_val("irq_req_raised", {31'h0, irq_req}, 32'h1);
        rd(12'h344, "mip_both", 32'h0000_0880);
        irq_ack = 1'b1;
        irq_pc  = 32'h0000_0123;
        tick();
        irq_ack = 1'b0;
        rd(12'h341, "ack_mepc", 32'h0000_0120);
        rd(12'h342, "ack_mcause_ext", 32'h8000_000B);
        rd(12'h300, "ack_mstatus", 32'h0000_1880);
        check_val("ack_irq_req", {31'h0, irq_req}, 32'h0);

        // mret restores MIE from MPIE
        WB_mret = 1'b1;
        tick();
        WB_mret = 1'b0;
        rd(12'h300, "mret_mstatus", 32'h0000_1888);
        check_val("mret_pc", mret_pc, 32'h0000_0120);
        check_val("mret_irq_req", {31'h0, irq_req}, 32'h1);

        // Trap entry beats a same-cycle mepc write
        irq_ack      = 1'b1;
        irq_pc       = 32'h0000_0556;
        WB_CSRWrite  = 1'b1;
        WB_CSR_waddr = 12'h341;
        WB_CSR_wdata = 32'h0000_0400;
        ext_irq      = 1'b0;
        tick();
        irq_ack     = 1'b0;
        WB_CSRWrite = 1'b0;
        rd(12'h341, "ack_vs_write_mepc", 32'h0000_0554);
        rd(12'h300, "ack_vs_write_mstatus", 32'h0000_1880);

        // Timer-only trap, taken together with an mret that must be discarded
        WB_mret = 1'b1;
        tick();
        WB_mret = 1'b0;
        rd(12'h344, "mip_tmr_only", 32'h0000_0080);
        check_val("tmr_irq_req", {31'h0, irq_req}, 32'h1);
        irq_ack = 1'b1;
        WB_mret = 1'b1;
        irq_pc  = 32'h0000_0204;
        tick();
        irq_ack = 1'b0;
        WB_mret = 1'b0;
        rd(12'h342, "ack_mcause_tmr", 32'h8000_0007);
        rd(12'h300, "ack_beats_mret", 32'h0000_1880);
        rd(12'h341, "ack_tmr_mepc", 32'h0000_0204);

        // irq_ack while nothing is requested is ignored
        irq_ack = 1'b1;
        irq_pc  = 32'h0000_0999;
        tick();
        irq_ack = 1'b0;
        rd(12'h341, "stray_ack_mepc", 32'h0000_0204);

        // mret beats a same-cycle mstatus write
        WB_mret      = 1'b1;
        WB_CSRWrite  = 1'b1;
        WB_CSR_waddr = 12'h300;
        WB_CSR_wdata = 32'h0;
        tick();
        WB_mret     = 1'b0;
        WB_CSRWrite = 1'b0;
        rd(12'h300, "mret_beats_write", 32'h0000_1888);

        // Trap entry does not block a write to an unrelated CSR
        irq_ack      = 1'b1;
        irq_pc       = 32'h0000_0310;
        WB_CSRWrite  = 1'b1;
        WB_CSR_waddr = 12'h340;
        WB_CSR_wdata = 32'hCAFE_0000;
        tick();
        irq_ack     = 1'b0;
        WB_CSRWrite = 1'b0;
        rd(12'h340, "ack_other_write", 32'hCAFE_0000);
        rd(12'h341, "ack_other_mepc", 32'h0000_0310);

        // Asynchronous reset with a request pending
        WB_mret = 1'b1;
        tick();
        WB_mret = 1'b0;
        check_val("pre_rst_irq_req", {31'h0, irq_req}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check_val("async_rst_irq_req", {31'h0, irq_req}, 32'h0);
        rd(12'h305, "async_rst_mtvec", 32'h0001_0000);
        rd(12'h340, "async_rst_mscratch", 32'h0);
        check_val("async_rst_mret_pc", mret_pc, 32'h0);
        tmr_irq = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00, "mcycle_wrap_lo", 32'h0);
        rd(12'hB80, "mcycle_wrap_hi", 32'h0);
        WB_retire = 1'b1;
        repeat (5) tick();
        WB_retire = 1'b0;
        rd(12'hB02, "minstret_5", 32'h5);
        rd(12'hC02, "instret_alias", 32'h5);
        rd(12'hB82, "minstret_hi", 32'h0);
        wr(12'hC02, 32'h0000_0100);
        rd(12'hB02, "instret_alias_ro", 32'h5);
`else
        wr(12'hB00, 32'h0000_0055);
        rd(12'hB00, "no_cnt_b00", 32'h0);
        WB_retire = 1'b1;
        repeat (5) tick();
        WB_retire = 1'b0;
        rd(12'hB02, "no_cnt_b02", 32'h0);
        rd(12'hC00, "no_cnt_c00", 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
